// File: rtl/bitcoin_nonce_scanner.sv
// bitcoin_nonce_scanner: multi-core double-SHA-256 nonce search over the
// second header block. Each core hashes one nonce per batch, one round per
// cycle. Optional macro BTC_SCAN_HASH_COUNT_EN adds a 64-bit hash_count port.
module bitcoin_nonce_scanner #(
  parameter int NUM_CORES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0][31:0]  midstate,
  input  logic [31:0]       merkle_tail,
  input  logic [31:0]       timestamp,
  input  logic [31:0]       target_bits,
  input  logic [31:0]       nonce_start,
  input  logic [31:0]       nonce_end,
  input  logic [255:0]      target,
  output logic              busy,
  output logic              done,
  output logic              found,
`ifdef BTC_SCAN_HASH_COUNT_EN
  output logic [63:0]       hash_count,
`endif
  output logic [31:0]       found_nonce,
  output logic [7:0][31:0]  found_digest
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HASH1, S_HASH2, S_CMP, S_DONE} state_t;

  // Word [i] holds H_i throughout (digests, midstate, IV).
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round; s[0]=a .. s[7]=h.
  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] s,
                                                 input logic [31:0] kt, input logic [31:0] wt);
    logic [31:0] t1, t2;
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + kt + wt;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {s[6], s[5], s[4], s[3] + t1, s[2], s[1], s[0], t1 + t2};
  endfunction

  // Digest as a 256-bit number: byte-reversed string, so H7 lands on top.
  function automatic logic [255:0] cmp_value(input logic [7:0][31:0] d);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) begin
      v[32*i +: 32] = bswap32(d[i]);
    end
    return v;
  endfunction

  state_t                state_r;
  logic [5:0]            rnd_r;
  logic [31:0]           base_r;
  logic [32:0]           rem_r;
  logic [7:0][31:0]      mid_r;
  logic [31:0]           tail_r, ts_r, bits_r;
  logic [255:0]          target_r;

  logic [NUM_CORES-1:0]  hit_s;
  logic [NUM_CORES-1:0]  en_s;
  logic [7:0][31:0]      dig_s [NUM_CORES];
  logic                  hit_any_s;
  logic [4:0]            win_s;
  logic [7:0][31:0]      win_dig_s;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    logic [7:0][31:0]  st_r;
    logic [15:0][31:0] w_r;
    logic              en_r;
    logic [7:0][31:0]  nxt_s, add1_s, add2_s;
    logic [31:0]       wnew_s;

    assign dig_s[k] = st_r;
    assign en_s[k]  = en_r;
    assign hit_s[k] = en_r && (cmp_value(st_r) <= target_r);

    // Next round state, next schedule word and the two add-back sums.
    always_comb begin
      nxt_s  = sha_round(st_r, K_TAB[rnd_r], w_r[0]);
      wnew_s = ssig1(w_r[14]) + w_r[9] + ssig0(w_r[1]) + w_r[0];
      for (int i = 0; i < 8; i++) begin
        add1_s[i] = mid_r[i] + nxt_s[i];
        add2_s[i] = IV[i] + nxt_s[i];
      end
    end

    // Core datapath: load block 1, run both hashes, keep the final digest.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_r <= '0;
        w_r  <= '0;
        en_r <= 1'b0;
      end else if (state_r == S_LOAD) begin
        st_r <= mid_r;
        w_r  <= {32'h00000280, 320'd0, 32'h80000000, bswap32(base_r + 32'(k)),
                 bswap32(bits_r), bswap32(ts_r), bswap32(tail_r)};
        en_r <= (33'(k) < rem_r);
      end else if (state_r == S_HASH1 && rnd_r == 6'd63) begin
        st_r <= IV;
        w_r  <= {32'h00000100, 192'd0, 32'h80000000, add1_s};
      end else if (state_r == S_HASH2 && rnd_r == 6'd63) begin
        st_r <= add2_s;
      end else if (state_r == S_HASH1 || state_r == S_HASH2) begin
        st_r <= nxt_s;
        w_r  <= {wnew_s, w_r[15:1]};
      end else begin
        st_r <= st_r;
      end
    end
  end

  // Lowest-index hitting core wins; it also carries the lowest nonce.
  always_comb begin
    hit_any_s = 1'b0;
    win_s     = 5'd0;
    win_dig_s = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (hit_s[k]) begin
        hit_any_s = 1'b1;
        win_s     = 5'(k);
        win_dig_s = dig_s[k];
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

`ifdef BTC_SCAN_HASH_COUNT_EN
  logic [4:0] en_cnt_s;

  // Number of enabled cores in the batch being compared.
  always_comb begin
    en_cnt_s = 5'd0;
    for (int k = 0; k < NUM_CORES; k++) begin
      en_cnt_s = en_cnt_s + {4'd0, en_s[k]};
    end
  end
`else
  logic unused_en_s;
  assign unused_en_s = ^en_s;
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      rnd_r        <= 6'd0;
      base_r       <= 32'd0;
      rem_r        <= 33'd0;
      mid_r        <= '0;
      tail_r       <= 32'd0;
      ts_r         <= 32'd0;
      bits_r       <= 32'd0;
      target_r     <= 256'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      found_nonce  <= 32'd0;
      found_digest <= '0;
`ifdef BTC_SCAN_HASH_COUNT_EN
      hash_count   <= 64'd0;
`endif
    end else if (abort && (state_r inside {S_LOAD, S_HASH1, S_HASH2, S_CMP})) begin
      state_r <= S_DONE;
      busy    <= 1'b0;
      done    <= 1'b1;
      found   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mid_r    <= midstate;
            tail_r   <= merkle_tail;
            ts_r     <= timestamp;
            bits_r   <= target_bits;
            target_r <= target;
            base_r   <= nonce_start;
            rem_r    <= {1'b0, nonce_end - nonce_start} + 33'd1;
            busy     <= 1'b1;
            found    <= 1'b0;
`ifdef BTC_SCAN_HASH_COUNT_EN
            hash_count <= 64'd0;
`endif
            state_r  <= S_LOAD;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_LOAD: begin
          rnd_r   <= 6'd0;
          state_r <= S_HASH1;
        end
        S_HASH1: begin
          rnd_r   <= rnd_r + 6'd1;
          state_r <= (rnd_r == 6'd63) ? S_HASH2 : S_HASH1;
        end
        S_HASH2: begin
          rnd_r   <= rnd_r + 6'd1;
          state_r <= (rnd_r == 6'd63) ? S_CMP : S_HASH2;
        end
        S_CMP: begin
`ifdef BTC_SCAN_HASH_COUNT_EN
          hash_count <= hash_count + {59'd0, en_cnt_s};
`endif
          base_r <= base_r + 32'(NUM_CORES);
          if (hit_any_s) begin
            found        <= 1'b1;
            found_nonce  <= base_r + {27'd0, win_s};
            found_digest <= win_dig_s;
            busy         <= 1'b0;
            done         <= 1'b1;
            state_r      <= S_DONE;
          end else if (rem_r <= 33'(NUM_CORES)) begin
            rem_r   <= 33'd0;
            found   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            rem_r   <= rem_r - 33'(NUM_CORES);
            state_r <= S_LOAD;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_nonce_scanner.sv
// Directed testbench for bitcoin_nonce_scanner (NUM_CORES = 4).
module tb_bitcoin_nonce_scanner;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [7:0][31:0]  midstate;
  logic [31:0]       merkle_tail, timestamp, target_bits, nonce_start, nonce_end;
  logic [255:0]      target;
  logic              busy, done, found;
  logic [31:0]       found_nonce;
  logic [7:0][31:0]  found_digest;
`ifdef BTC_SCAN_HASH_COUNT_EN
  logic [63:0]       hash_count;
`endif

  int checks = 0;
  int errors = 0;
  int dcyc;
  logic gap;
  logic [255:0] tgt_blk;
  int seen;

  bitcoin_nonce_scanner #(.NUM_CORES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .midstate(midstate), .merkle_tail(merkle_tail), .timestamp(timestamp),
    .target_bits(target_bits), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .busy(busy), .done(done), .found(found),
`ifdef BTC_SCAN_HASH_COUNT_EN
    .hash_count(hash_count),
`endif
    .found_nonce(found_nonce), .found_digest(found_digest));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a search; return the cycle (counted from the start edge) when done is seen.
  task automatic run_search(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg,
                            input logic abort_with_start, input int abort_at, input int restart_at,
                            input int budget, output int done_cyc, output logic busy_gap);
    repeat (2) @(negedge clk);
    nonce_start = ns;
    nonce_end   = ne;
    target      = tg;
    start       = 1'b1;
    abort       = abort_with_start;
    @(posedge clk);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
    done_cyc = -1;
    busy_gap = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (!busy) busy_gap = 1'b1;
      if (c == abort_at) abort = 1'b1;
      if (c == restart_at) begin
        start       = 1'b1;
        nonce_start = ns + 32'h30;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    midstate    = {32'hfc48d2df, 32'h95f0172e, 32'h4cbb9b8f, 32'hc3c1b9e4,
                   32'he536f7d5, 32'hcb1a5434, 32'h0c69421a, 32'hdc6a3b8d};
    merkle_tail = 32'h871714dc;
    timestamp   = 32'h53058b35;
    target_bits = 32'h19015f53;
    nonce_start = 32'd0;
    nonce_end   = 32'd0;
    target      = 256'd0;
    tgt_blk     = 256'h015f53 << 176;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_found", {63'd0, found}, 64'd0);
    check("reset_nonce", {32'd0, found_nonce}, 64'd0);
    check("reset_digest_or", {63'd0, |found_digest}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Real header, hit in the third batch.
    run_search(32'h33087540, 32'h3308754f, tgt_blk, 1'b0, -1, -1, 1000, dcyc, gap);
    check("A_done_cycle", 64'(dcyc), 64'd390);
    check("A_busy_gap", {63'd0, gap}, 64'd0);
    check("A_busy_at_done", {63'd0, busy}, 64'd0);
    check("A_found", {63'd0, found}, 64'd1);
    check("A_nonce", {32'd0, found_nonce}, 64'h33087548);
    check("A_dig7", {32'd0, found_digest[7]}, 64'h00000000);
    check("A_dig6", {32'd0, found_digest[6]}, 64'h00000000);
    check("A_dig5", {32'd0, found_digest[5]}, 64'h78a467e0);
    @(posedge clk);
    #1;
    check("A_done_one_cycle", {63'd0, done}, 64'd0);

    // Range without a hit: two batches, previous result held.
    run_search(32'h33087549, 32'h33087550, tgt_blk, 1'b0, -1, -1, 1000, dcyc, gap);
    check("B_done_cycle", 64'(dcyc), 64'd260);
    check("B_found", {63'd0, found}, 64'd0);
    check("B_nonce_held", {32'd0, found_nonce}, 64'h33087548);
`ifdef BTC_SCAN_HASH_COUNT_EN
    check("B_hash_count", hash_count, 64'd8);
`endif

    // Everything qualifies: lowest core wins; a start pulse while busy is ignored.
    run_search(32'h00000010, 32'h0000001f, {256{1'b1}}, 1'b0, -1, 60, 1000, dcyc, gap);
    check("C_done_cycle", 64'(dcyc), 64'd130);
    check("C_found", {63'd0, found}, 64'd1);
    check("C_nonce", {32'd0, found_nonce}, 64'h10);

    // Wrapping range, target 0; start with abort in IDLE is still accepted.
    run_search(32'hfffffffe, 32'h00000001, 256'd0, 1'b1, -1, -1, 1000, dcyc, gap);
    check("D_done_cycle", 64'(dcyc), 64'd130);
    check("D_found", {63'd0, found}, 64'd0);
    check("D_nonce_held", {32'd0, found_nonce}, 64'h10);
`ifdef BTC_SCAN_HASH_COUNT_EN
    check("D_hash_count", hash_count, 64'd4);
`endif

    // Partial last batch.
    run_search(32'h00000000, 32'h00000005, 256'd0, 1'b0, -1, -1, 1000, dcyc, gap);
    check("E_done_cycle", 64'(dcyc), 64'd260);
    check("E_found", {63'd0, found}, 64'd0);
`ifdef BTC_SCAN_HASH_COUNT_EN
    check("E_hash_count", hash_count, 64'd6);
`endif

    // Abort at cycle 100 of a long search.
    run_search(32'h00000000, 32'h0000ffff, 256'd0, 1'b0, 100, -1, 1000, dcyc, gap);
    check("F_done_cycle", 64'(dcyc), 64'd101);
    check("F_found", {63'd0, found}, 64'd0);
    check("F_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of HASH2: outputs clear, no done pulse follows.
    repeat (2) @(negedge clk);
    nonce_start = 32'd0;
    nonce_end   = 32'h0000ffff;
    target      = 256'd0;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("G_busy_before_reset", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #2;
    check("G_busy", {63'd0, busy}, 64'd0);
    check("G_found", {63'd0, found}, 64'd0);
    check("G_nonce", {32'd0, found_nonce}, 64'd0);
    check("G_digest_or", {63'd0, |found_digest}, 64'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("G_no_done_after_reset", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
